btb_gshare_predictor: RTL and testbench

//  Parametrised, tagged branch target buffer with 2-bit saturating counters, selectable

---
 rtl/btb_gshare_predictor_if.sv | 31 +++
 rtl/btb_gshare_predictor.sv | 90 +++++++++
 tb/tb_btb_gshare_predictor.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/btb_gshare_predictor_if.sv
// Fetch-lookup, commit-update and perf-counter signals of the BTB/gshare predictor.
// The master modport is the pipeline side and the slave modport is the predictor.
interface btb_gshare_predictor_if #(
  parameter int IDX_W  = 4,
  parameter int PERF_W = 16
);
  logic [31:0]       lu_pc;
  logic              lu_hit;
  logic              lu_predict;
  logic [31:0]       lu_target;
  logic [IDX_W-1:0]  lu_index;
  logic              up_en;
  logic [IDX_W-1:0]  up_index;
  logic [31:0]       up_pc;
  logic              up_taken;
  logic [31:0]       up_target;
  logic              up_mispred;
  logic              flush;
  logic [PERF_W-1:0] perf_br;
  logic [PERF_W-1:0] perf_miss;

  modport master (
    output lu_pc, up_en, up_index, up_pc, up_taken, up_target, up_mispred, flush,
    input  lu_hit, lu_predict, lu_target, lu_index, perf_br, perf_miss
  );

  modport slave (
    input  lu_pc, up_en, up_index, up_pc, up_taken, up_target, up_mispred, flush,
    output lu_hit, lu_predict, lu_target, lu_index, perf_br, perf_miss
  );
endinterface

// File: rtl/btb_gshare_predictor.sv
// Tagged BTB with 2-bit counters and bimodal/gshare indexing; lookup is combinational.
// Training arrives from commit with the fetch-time index and takes effect on the next edge.
module btb_gshare_predictor #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int HIST_W  = 4,
  parameter int GSHARE  = 1,
  parameter int PERF_W  = 16
) (
  input  logic CLK,
  input  logic RST,
  btb_gshare_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid;
  logic [1:0]         ctr [ENTRIES];
  logic [TAG_W-1:0]   tag [ENTRIES];
  logic [31:0]        tgt [ENTRIES];
  logic [HIST_W-1:0]  ghr;
  logic [HIST_W:0]    ghr_sh;
  logic [IDX_W-1:0]   ghr_ext;
  logic [IDX_W-1:0]   lu_idx;
  logic [TAG_W-1:0]   lu_tag;
  logic [TAG_W-1:0]   up_tag;
  logic               up_match;
  logic [1:0]         up_cur;
  logic [1:0]         up_ctr;
  logic [PERF_W-1:0]  perf_br_q;
  logic [PERF_W-1:0]  perf_miss_q;
  logic               unused_pc_bits;

  assign unused_pc_bits = ^{bp.lu_pc, bp.up_pc};
  assign ghr_sh         = {ghr, bp.up_taken};
  assign lu_tag         = bp.lu_pc[IDX_W+2 +: TAG_W];
  assign up_tag         = bp.up_pc[IDX_W+2 +: TAG_W];

  always_comb begin
    ghr_ext = '0;
    ghr_ext[HIST_W-1:0] = ghr;
    lu_idx = bp.lu_pc[IDX_W+1:2];
    if (GSHARE != 0) lu_idx = lu_idx ^ ghr_ext;
  end

  assign bp.lu_index   = lu_idx;
  assign bp.lu_hit     = valid[lu_idx] && (tag[lu_idx] == lu_tag);
  assign bp.lu_predict = bp.lu_hit && ctr[lu_idx][1];
  assign bp.lu_target  = tgt[lu_idx];
  assign bp.perf_br    = perf_br_q;
  assign bp.perf_miss  = perf_miss_q;

  assign up_match = valid[bp.up_index] && (tag[bp.up_index] == up_tag);
  assign up_cur   = ctr[bp.up_index];

  always_comb begin
    up_ctr = up_cur;
    if (!up_match)
      up_ctr = bp.up_taken ? 2'b10 : 2'b01;
    else if (bp.up_taken)
      up_ctr = (up_cur == 2'b11) ? up_cur : up_cur + 2'd1;
    else
      up_ctr = (up_cur == 2'b00) ? up_cur : up_cur - 2'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid       <= '0;
      ghr         <= '0;
      perf_br_q   <= '0;
      perf_miss_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= 2'b01;
        tag[i] <= '0;
        tgt[i] <= '0;
      end
    end else if (bp.flush) begin
      // A flushed cycle drops the whole update, including its perf contribution.
      valid <= '0;
      ghr   <= '0;
    end else if (bp.up_en) begin
      valid[bp.up_index] <= 1'b1;
      tag[bp.up_index]   <= up_tag;
      ctr[bp.up_index]   <= up_ctr;
      if (!up_match || bp.up_taken) tgt[bp.up_index] <= bp.up_target;
      ghr <= ghr_sh[HIST_W-1:0];
      if (perf_br_q != '1) perf_br_q <= perf_br_q + 1'b1;
      if (bp.up_mispred && (perf_miss_q != '1)) perf_miss_q <= perf_miss_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_btb_gshare_predictor.sv
// Directed bench: bimodal instance (PERF_W=4) and gshare instance share clock and reset.
module tb_btb_gshare_predictor;
  logic CLK = 1'b0;
  logic RST;
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  btb_gshare_predictor_if #(.IDX_W(4), .PERF_W(4))  ia ();
  btb_gshare_predictor_if #(.IDX_W(4), .PERF_W(16)) ig ();

  btb_gshare_predictor #(.ENTRIES(16), .TAG_W(8), .HIST_W(4), .GSHARE(0), .PERF_W(4)) dut_a (
    .CLK(CLK), .RST(RST), .bp(ia)
  );
  btb_gshare_predictor #(.ENTRIES(16), .TAG_W(8), .HIST_W(4), .GSHARE(1), .PERF_W(16)) dut_g (
    .CLK(CLK), .RST(RST), .bp(ig)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic upd_a(input logic [3:0] idx, input logic [31:0] pc, input logic tk,
                       input logic [31:0] t, input logic mis);
    ia.up_en = 1'b1; ia.up_index = idx; ia.up_pc = pc;
    ia.up_taken = tk; ia.up_target = t; ia.up_mispred = mis;
    step();
    ia.up_en = 1'b0;
  endtask

  task automatic upd_g(input logic [3:0] idx, input logic [31:0] pc, input logic tk,
                       input logic [31:0] t);
    ig.up_en = 1'b1; ig.up_index = idx; ig.up_pc = pc;
    ig.up_taken = tk; ig.up_target = t; ig.up_mispred = 1'b0;
    step();
    ig.up_en = 1'b0;
  endtask

  task automatic look_a(input logic [31:0] pc);
    ia.lu_pc = pc;
    #1;
  endtask

  task automatic look_g(input logic [31:0] pc);
    ig.lu_pc = pc;
    #1;
  endtask

  initial begin
    RST = 1'b1;
    ia.lu_pc = '0; ia.up_en = 1'b0; ia.up_index = '0; ia.up_pc = '0;
    ia.up_taken = 1'b0; ia.up_target = '0; ia.up_mispred = 1'b0; ia.flush = 1'b0;
    ig.lu_pc = '0; ig.up_en = 1'b0; ig.up_index = '0; ig.up_pc = '0;
    ig.up_taken = 1'b0; ig.up_target = '0; ig.up_mispred = 1'b0; ig.flush = 1'b0;
    step();
    step();
    RST = 1'b0;

    // Reset state
    look_a(32'h40);
    chk("rst_hit",    32'(ia.lu_hit), 32'd0);
    chk("rst_pred",   32'(ia.lu_predict), 32'd0);
    chk("rst_tgt",    ia.lu_target, 32'd0);
    chk("rst_idx",    32'(ia.lu_index), 32'd0);
    chk("rst_br",     32'(ia.perf_br), 32'd0);
    chk("rst_miss",   32'(ia.perf_miss), 32'd0);

    // Allocate taken; same-cycle lookup must still see the old (invalid) entry
    ia.up_en = 1'b1; ia.up_index = 4'd0; ia.up_pc = 32'h40;
    ia.up_taken = 1'b1; ia.up_target = 32'h100; ia.up_mispred = 1'b0;
    #1;
    chk("nobypass_hit", 32'(ia.lu_hit), 32'd0);
    step();
    ia.up_en = 1'b0;
    look_a(32'h40);
    chk("alloc_hit",  32'(ia.lu_hit), 32'd1);
    chk("alloc_pred", 32'(ia.lu_predict), 32'd1);
    chk("alloc_tgt",  ia.lu_target, 32'h100);
    upd_a(4'd0, 32'h40, 1'b0, 32'h999, 1'b0);
    look_a(32'h40);
    chk("nt_pred",    32'(ia.lu_predict), 32'd0);
    chk("nt_tgt_kept", ia.lu_target, 32'h100);

    // Saturation: 01 -> 10 -> 11 -> 11 -> 11, then 10, then 01
    for (int i = 0; i < 4; i++) upd_a(4'd0, 32'h40, 1'b1, 32'h200, 1'b0);
    upd_a(4'd0, 32'h40, 1'b0, 32'h0, 1'b0);
    look_a(32'h40);
    chk("sat_pred1",  32'(ia.lu_predict), 32'd1);
    chk("sat_tgt",    ia.lu_target, 32'h200);
    upd_a(4'd0, 32'h40, 1'b0, 32'h0, 1'b0);
    look_a(32'h40);
    chk("sat_pred0",  32'(ia.lu_predict), 32'd0);

    // Aliasing: 0x440 shares index 0 with 0x40 but carries tag 0x11
    look_a(32'h440);
    chk("alias_idx",  32'(ia.lu_index), 32'd0);
    chk("alias_miss", 32'(ia.lu_hit), 32'd0);
    upd_a(4'd0, 32'h440, 1'b1, 32'h300, 1'b0);
    look_a(32'h40);
    chk("alias_old_miss", 32'(ia.lu_hit), 32'd0);
    look_a(32'h440);
    chk("alias_new_hit", 32'(ia.lu_hit), 32'd1);
    chk("alias_new_tgt", ia.lu_target, 32'h300);
    chk("perf_br_9",  32'(ia.perf_br), 32'd9);
    chk("perf_miss_0", 32'(ia.perf_miss), 32'd0);

    // Gshare: three taken updates at index 1 (pc 0x80, tag 2) -> GHR 0111
    for (int i = 0; i < 3; i++) upd_g(4'd1, 32'h80, 1'b1, 32'h500);
    look_g(32'h40);
    chk("gs_idx7",    32'(ig.lu_index), 32'd7);
    chk("gs_idx7_miss", 32'(ig.lu_hit), 32'd0);
    look_g(32'h98);
    chk("gs_idx1",    32'(ig.lu_index), 32'd1);
    chk("gs_hit",     32'(ig.lu_hit), 32'd1);
    chk("gs_pred",    32'(ig.lu_predict), 32'd1);
    chk("gs_tgt",     ig.lu_target, 32'h500);
    chk("gs_br3",     32'(ig.perf_br), 32'd3);
    ig.flush = 1'b1;
    step();
    ig.flush = 1'b0;
    look_g(32'h40);
    chk("fl_ghr0",    32'(ig.lu_index), 32'd0);
    look_g(32'h84);
    chk("fl_idx1",    32'(ig.lu_index), 32'd1);
    chk("fl_miss",    32'(ig.lu_hit), 32'd0);
    chk("fl_br_kept", 32'(ig.perf_br), 32'd3);
    ig.flush = 1'b1;
    upd_g(4'd1, 32'h84, 1'b1, 32'h600);
    ig.flush = 1'b0;
    look_g(32'h84);
    chk("flup_idx",   32'(ig.lu_index), 32'd1);
    chk("flup_miss",  32'(ig.lu_hit), 32'd0);

    // Perf saturation at 4 bits, then reset mid-stream
    for (int i = 0; i < 20; i++) upd_a(4'd0, 32'h440, 1'b1, 32'h300, 1'b1);
    chk("sat_br15",   32'(ia.perf_br), 32'd15);
    chk("sat_miss15", 32'(ia.perf_miss), 32'd15);
    ia.up_en = 1'b1; ia.up_mispred = 1'b1;
    RST = 1'b1;
    step();
    RST = 1'b0;
    ia.up_en = 1'b0;
    look_a(32'h440);
    chk("mrst_br",    32'(ia.perf_br), 32'd0);
    chk("mrst_miss",  32'(ia.perf_miss), 32'd0);
    chk("mrst_hit",   32'(ia.lu_hit), 32'd0);
    chk("mrst_tgt",   ia.lu_target, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
